// File: rtl/unidade_busca_pkg.sv
// Shared definitions for the instruction-fetch stage:
// FSM encoding, the NOP/halt word and instruction field positions.
package unidade_busca_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } estado_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

endpackage

// File: rtl/unidade_busca_if.sv
// Instruction memory bus: byte address out, word back (combinational read).
// master = fetch stage, slave = instruction memory.
interface unidade_busca_if;

    logic [31:0] mem_addr;
    logic [31:0] mem_instr;

    modport master (
        output mem_addr,
        input  mem_instr
    );

    modport slave (
        input  mem_addr,
        output mem_instr
    );

endinterface

// File: rtl/unidade_busca_calc_proximo_pc.sv
// Combinational next-PC: sequential / beq / j selection and range flag.
// Ports: pc, imm, target, branch_taken, jump in; pc_plus4, pc_next, fora out.
module calc_proximo_pc #(
    parameter int MEM_BYTES = 1024
) (
    input  logic [31:0] pc,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    input  logic        branch_taken,
    input  logic        jump,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_next,
    output logic        fora
);

    logic [31:0] desl;

    assign pc_plus4 = pc + 32'd4;
    assign desl     = {{14{imm[15]}}, imm, 2'b00};

    // jump outranks branch_taken when both are asserted
    always_comb begin
        pc_next = pc_plus4;
        if (jump) begin
            pc_next = {pc_plus4[31:28], target, 2'b00};
        end else if (branch_taken) begin
            pc_next = pc_plus4 + desl;
        end
    end

    // a wrapped (negative) target is a huge unsigned value, so it lands here too
    assign fora = (pc_next >= 32'(MEM_BYTES));

endmodule

// File: rtl/unidade_busca.sv
// Fetch stage: PC register, run/halt/fault FSM, retired-instruction counter.
// Ports: clk, reset, mem bus, stall/branch_taken/jump in; instr, pc, status out.
module unidade_busca
    import unidade_busca_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          MEM_BYTES    = 1024,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    unidade_busca_if.master        mem,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic                   jump,
    output logic [31:0]            instr,
    output logic                   instr_valid,
    output logic [31:0]            pc,
    output logic [31:0]            pc_plus4,
    output logic                   halted,
    output logic                   fault,
    output logic [31:0]            instr_count
);

    estado_t     estado_q, estado_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pc_next;
    logic        fora;

    calc_proximo_pc #(
        .MEM_BYTES (MEM_BYTES)
    ) u_calc (
        .pc           (pc_q),
        .imm          (mem.mem_instr[IMM_MSB:IMM_LSB]),
        .target       (mem.mem_instr[TARGET_MSB:TARGET_LSB]),
        .branch_taken (branch_taken),
        .jump         (jump),
        .pc_plus4     (pc_plus4),
        .pc_next      (pc_next),
        .fora         (fora)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= START;
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        estado_d    = estado_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        instr       = NOP_WORD;
        instr_valid = 1'b0;
        unique case (estado_q)
            START: begin
                estado_d = RUN;
            end
            RUN: begin
                // visible while stalled, but only retired when not
                instr = mem.mem_instr;
                if (!stall) begin
                    instr_valid = 1'b1;
                    if (cnt_q != 32'hFFFF_FFFF) begin
                        cnt_d = cnt_q + 32'd1;
                    end
                    if (HALT_ON_ZERO && mem.mem_instr == NOP_WORD) begin
                        estado_d = HALT;
                    end else if (fora) begin
                        estado_d = FAULT;
                    end else begin
                        pc_d = pc_next;
                    end
                end
            end
            HALT: begin
            end
            FAULT: begin
            end
            default: begin
                estado_d = START;
            end
        endcase
    end

    assign pc           = pc_q;
    assign mem.mem_addr = pc_q;
    assign instr_count  = cnt_q;
    assign halted       = (estado_q == HALT);
    assign fault        = (estado_q == FAULT);

endmodule

// File: tb/tb_unidade_busca.sv
// Self-checking bench for unidade_busca: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_unidade_busca;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic        jump;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        fault;
    logic [31:0] instr_count;

    logic [31:0] mem [256];

    int n_pass = 0;
    int n_total = 0;

    unidade_busca_if bif ();

    assign bif.mem_instr = mem[bif.mem_addr[9:2]];

    unidade_busca dut (
        .clk          (clk),
        .reset        (reset),
        .mem          (bif.master),
        .stall        (stall),
        .branch_taken (branch_taken),
        .jump         (jump),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .halted       (halted),
        .fault        (fault),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_default();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0020;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        jump = 1'b0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        fill_default();
        reset = 1'b1;
        stall = 1'b1;
        branch_taken = 1'b1;
        jump = 1'b1;
        tick();
        tick();
        #1;
        chk("reset_pc", pc, 32'h0);
        chk("reset_addr", bif.mem_addr, 32'h0);
        chk("reset_cnt", instr_count, 32'h0);
        chk("reset_halted", {31'h0, halted}, 32'h0);
        chk("reset_fault", {31'h0, fault}, 32'h0);
        chk("reset_valid", {31'h0, instr_valid}, 32'h0);
        chk("reset_instr", instr, 32'h0);
    endtask

    task automatic test_sequencial();
        fill_default();
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h0109_5020;
        do_reset();
        chk("start_valid", {31'h0, instr_valid}, 32'h0);
        chk("start_pc", pc, 32'h0);
        tick();
        #1;
        chk("run0_valid", {31'h0, instr_valid}, 32'h1);
        chk("run0_instr", instr, 32'h2008_0001);
        chk("run0_pc4", pc_plus4, 32'h4);
        tick();
        chk("seq_pc4", pc, 32'h4);
        tick();
        chk("seq_pc8", pc, 32'h8);
        tick();
        chk("seq_pcC", pc, 32'hC);
        chk("seq_cnt", instr_count, 32'd3);
    endtask

    task automatic test_branch_jump();
        for (int tk = 1; tk >= 0; tk--) begin
            fill_default();
            mem[7] = 32'h1000_0001;
            mem[8] = 32'h0800_0010;
            mem[17] = 32'h0;
            do_reset();
            tick();
            for (int i = 0; i < 7; i++) tick();
            chk("br_at_1c", pc, 32'h1C);
            branch_taken = tk[0];
            tick();
            branch_taken = 1'b0;
            #1;
            chk(tk ? "beq_taken" : "beq_not", pc,
                tk ? 32'h24 : 32'h20);
        end
        jump = 1'b1;
        branch_taken = 1'b1;
        tick();
        jump = 1'b0;
        branch_taken = 1'b0;
        #1;
        chk("jump_wins", pc, 32'h40);
        tick();
        chk("pre_halt_pc", pc, 32'h44);
        tick();
        chk("halt_flag", {31'h0, halted}, 32'h1);
        chk("halt_pc", pc, 32'h44);
        chk("halt_instr", instr, 32'h0);
        chk("halt_cnt", instr_count, 32'd11);
        stall = 1'b0;
        jump = 1'b1;
        tick();
        jump = 1'b0;
        #1;
        chk("halt_hold_pc", pc, 32'h44);
        chk("halt_hold_v", {31'h0, instr_valid}, 32'h0);
        reset = 1'b1;
        stall = 1'b1;
        tick();
        reset = 1'b0;
        stall = 1'b0;
        #1;
        chk("halt_rst_pc", pc, 32'h0);
        chk("halt_rst_h", {31'h0, halted}, 32'h0);
        chk("halt_rst_v", {31'h0, instr_valid}, 32'h0);
    endtask

    task automatic test_stall();
        fill_default();
        do_reset();
        tick();
        tick();
        tick();
        chk("stall_pre", pc, 32'h8);
        stall = 1'b1;
        branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_pc", pc, 32'h8);
            chk("stall_v", {31'h0, instr_valid}, 32'h0);
            chk("stall_instr", instr, mem[2]);
            chk("stall_cnt", instr_count, 32'd2);
            tick();
        end
        stall = 1'b0;
        branch_taken = 1'b0;
        #1;
        chk("stall_rel_v", {31'h0, instr_valid}, 32'h1);
        tick();
        chk("stall_rel_pc", pc, 32'hC);
        chk("stall_rel_cnt", instr_count, 32'd3);
    endtask

    task automatic test_fault();
        fill_default();
        mem[0] = 32'h1000_FFFE;
        do_reset();
        tick();
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        #1;
        chk("fault_flag", {31'h0, fault}, 32'h1);
        chk("fault_pc", pc, 32'h0);
        chk("fault_cnt", instr_count, 32'd1);
        for (int i = 0; i < 4; i++) begin
            stall = 1'($urandom);
            jump = 1'($urandom);
            tick();
        end
        stall = 1'b0;
        jump = 1'b0;
        #1;
        chk("fault_stay", {31'h0, fault}, 32'h1);
        chk("fault_instr", instr, 32'h0);
        chk("fault_addr", bif.mem_addr, 32'h0);
        do_reset();
        chk("fault_rst", {31'h0, fault}, 32'h0);
    endtask

    task automatic test_random();
        typedef enum {M_START, M_RUN, M_HALT, M_FAULT} modo_t;
        modo_t       modo;
        logic [31:0] mpc;
        logic [31:0] mcnt;
        logic [31:0] w;
        logic [130:0] act, exp;
        longint      alvo;
        int          preso;
        int          r;
        for (int i = 0; i < 256; i++) begin
            r = $urandom_range(0, 15);
            w = $urandom;
            if (r == 0) mem[i] = 32'h0;
            else if (r == 1) mem[i] = w;
            else mem[i] = {w[31:26], 18'h0, w[7:0]};
        end
        do_reset();
        modo = M_START;
        mpc = 32'h0;
        mcnt = 32'h0;
        preso = 0;
        for (int c = 0; c < 800; c++) begin
            if (modo == M_HALT || modo == M_FAULT) preso++;
            reset = (preso > 2) || ($urandom_range(0, 99) == 0);
            stall = ($urandom_range(0, 3) == 0);
            branch_taken = 1'($urandom);
            jump = ($urandom_range(0, 3) == 0);
            #1;
            w = mem[mpc[9:2]];
            exp = {mpc, mpc + 32'd4,
                   (modo == M_RUN) ? w : 32'h0,
                   modo == M_RUN && !stall, mcnt,
                   modo == M_HALT, modo == M_FAULT};
            act = {pc, pc_plus4, instr, instr_valid, instr_count,
                   halted, fault};
            n_total++;
            if (act !== exp)
                $display("FAIL rand cyc %0d: got %h expected %h",
                         c, act, exp);
            else
                n_pass++;
            if (reset) begin
                modo = M_START;
                mpc = 32'h0;
                mcnt = 32'h0;
                preso = 0;
            end else if (modo == M_START) begin
                modo = M_RUN;
            end else if (modo == M_RUN && !stall) begin
                if (mcnt != 32'hFFFF_FFFF) mcnt++;
                if (jump)
                    alvo = ((longint'(mpc) + 4) & 64'hF000_0000)
                           + longint'(w[25:0]) * 4;
                else if (branch_taken)
                    alvo = (longint'(mpc) + 4
                            + longint'($signed(w[15:0])) * 4)
                           & 64'hFFFF_FFFF;
                else
                    alvo = longint'(mpc) + 4;
                if (w == 32'h0) modo = M_HALT;
                else if (alvo >= 1024) modo = M_FAULT;
                else mpc = 32'(alvo);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        jump = 1'b0;
        test_reset();
        test_sequencial();
        test_branch_jump();
        test_stall();
        test_fault();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/unidade_busca.md
Name: unidade_busca

Overview:
- Instruction-fetch stage of the single-cycle MIPS core. Sits directly upstream of the instruction memory.
- Holds the PC, drives the memory word address, and passes the returned instruction to decode in the same cycle.
- Computes the next PC from sequential, branch and jump requests issued by control/ALU for the current instruction.
- Includes a run/halt state machine and a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- MEM_BYTES, 1024, instruction memory size in bytes (256 words); a PC at or above this value is out of range.
- HALT_ON_ZERO, 1, when 1, fetching 32'h00000000 halts the core.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- mem_addr  out  32  byte address to instruction memory; equals pc.
- mem_instr  in  32  word returned combinationally by instruction memory.
- stall  in  1  hold PC and FSM this cycle.
- branch_taken  in  1  beq condition true for the current instruction.
- jump  in  1  current instruction is j.
- instr  out  32  instruction to decode; 0 when not RUN.
- instr_valid  out  1  high only in RUN with stall low.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, combinational.
- halted  out  1  FSM in HALT.
- fault  out  1  FSM in FAULT.
- instr_count  out  32  number of instructions retired.

Behaviour:
- Reset (synchronous, active-high): pc=RESET_PC, state=START, instr_count=0. Reset has priority over every other input, including mid-halt and mid-stall.
- Reset-time output values: halted=0, fault=0, instr_valid=0, instr=0.
- FSM states: START, RUN, HALT, FAULT.
- START: one cycle, no fetch issued. Next state is RUN; pc is unchanged.
- RUN, stall=1: pc, state and counter are held. instr_valid=0 and instr=mem_instr (observable but not retired).
- RUN, stall=0: instr_valid=1, instr=mem_instr. At the clock edge instr_count increments and pc is updated with this priority:
  - jump: {pc_plus4[31:28], mem_instr[25:0], 2'b00}
  - else branch_taken: pc_plus4 + (sign-extended mem_instr[15:0] << 2)
  - else: pc_plus4
- If jump and branch_taken are both high, jump wins.
- Halt: in RUN with stall=0, HALT_ON_ZERO=1 and mem_instr==0, the zero word retires (count +1). pc is held and the next state is HALT.
- Fault: in RUN with stall=0, if the computed next pc >= MEM_BYTES, the next state is FAULT and pc is held at the last valid value. The current instruction still retires.
- HALT and FAULT are absorbing until reset. In both, instr=0, instr_valid=0, and pc and the counter are frozen. Inputs are ignored.
- Arithmetic is 32-bit modulo 2^32, so a branch offset can wrap below 0. The wrapped value is >= MEM_BYTES and therefore raises FAULT.
- pc[1:0] is always 00: RESET_PC is aligned and every next-PC path produces aligned values.
- instr_count saturates at 32'hFFFF_FFFF.
- mem_addr = pc at all times, including in HALT and FAULT.

Decomposition:
- Shared package:
  - FSM state encoding: START=2'd0, RUN=2'd1, HALT=2'd2, FAULT=2'd3.
  - Constant NOP_WORD=32'h0.
  - Field positions: IMM 15:0, TARGET 25:0.
- One natural sub-module, calc_proximo_pc: purely combinational next-PC computation (sequential/branch/jump mux plus out-of-range flag).
- The FSM, PC register and counter stay in the top module.

Test Plan:
- Reset then free run with a memory of addi, addi, add: cycle 0 is START (instr_valid=0). pc then goes 0→4→8→C, instr_count=3 after three RUN cycles.
- At pc=0x1C, beq imm=1 with branch_taken=1: next pc=0x24. With branch_taken=0: next pc=0x20.
- At pc=0x20, j 16 (0x08000010) with jump=1 and branch_taken=1 together: next pc=0x40, because jump wins.
- stall held for 3 cycles at pc=0x8: pc stays 0x8, instr_valid=0, count unchanged. Release gives pc=0xC next edge.
- Word 0 fetched at pc=0x44: halted=1 the next cycle, pc stays 0x44, instr=0, count includes the zero word. Asserting reset returns pc=0 and state to START.
- beq at pc=0 with imm=0xFFFE, branch_taken=1: target wraps to 0xFFFFFFFC, so fault=1, pc stays 0, and the FSM stays in FAULT until reset.
